video_to_fifo_ctrl: RTL and testbench

Capture-side counterpart of the DDR video output path. Samples a 24-bit RGB video stream and packs consecutive active pixels into AXI-width words. Writes the words into the write-side FIFO and raises one AXI full-burst write request per completed active line through a valid/ready handshake. Sits between the video input timing and the AXI write master in the video-ddr subsystem.

---
 rtl/video_ddr_pkg.sv | 14 +
 rtl/video_pixel_packer.sv | 71 +++++++
 rtl/video_to_fifo_ctrl.sv | 96 +++++++++
 tb/tb_video_to_fifo_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/video_ddr_pkg.sv
// Shared helpers for the video/DDR path: lane geometry and request-queue sizing.
// The capture and read-out sides must agree on lane placement.
package video_ddr_pkg;
  localparam int PEND_W = 2;

  function automatic int lanes_of(input int w);
    return w / 32;
  endfunction

  // First pixel of a word lands in the most significant 32-bit lane.
  function automatic int lane_off(input int w, input int k);
    return w - 32 * (k + 1);
  endfunction
endpackage

// File: rtl/video_pixel_packer.sv
// Packs 24-bit pixels into W-bit words and issues the registered FIFO write strobe.
// A full word is written when its last lane is captured; line end flushes a partial word.
module video_pixel_packer
  import video_ddr_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         pix_vld_i,
  input  logic         line_end_i,
  input  logic         fifo_full_i,
  input  logic [23:0]  pix_i,
  output logic [W-1:0] fifo_data_o,
  output logic         fifo_wr_en_o,
  output logic         drop_o
);
  localparam int LANES = lanes_of(W);
  localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LCW-1:0] lane_cnt_q, lane_cnt_d;
  logic [W-1:0]   pack_q, pack_d, data_q, data_d, wr_word;
  logic           wr_q, wr_d, wr_req;

  always_comb begin
    lane_cnt_d = lane_cnt_q;
    pack_d     = pack_q;
    wr_word    = pack_q;
    wr_req     = 1'b0;
    if (clr_i) begin
      lane_cnt_d = '0;
      pack_d     = '0;
    end else if (pix_vld_i) begin
      wr_word[lane_off(W, int'(lane_cnt_q)) +: 32] = {8'h00, pix_i};
      if (lane_cnt_q == LCW'(LANES - 1)) begin
        wr_req     = 1'b1;
        lane_cnt_d = '0;
        pack_d     = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + LCW'(1);
        pack_d     = wr_word;
      end
    end else if (line_end_i && lane_cnt_q != '0) begin
      // pack register is zeroed after every write, so unfilled lanes are already 0
      wr_req     = 1'b1;
      lane_cnt_d = '0;
      pack_d     = '0;
    end
    wr_d   = wr_req & ~fifo_full_i;
    drop_o = wr_req & fifo_full_i;
    data_d = wr_d ? wr_word : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q <= '0;
      pack_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      pack_q     <= pack_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
    end
  end

  assign fifo_data_o  = data_q;
  assign fifo_wr_en_o = wr_q;
endmodule

// File: rtl/video_to_fifo_ctrl.sv
// Video capture front end: frame/line tracking, pixel packing into the write FIFO,
// and a small saturating queue of per-line AXI burst requests.
module video_to_fifo_ctrl
  import video_ddr_pkg::*;
#(
  parameter int H_DISP          = 1920,
  parameter int V_DISP          = 1080,
  parameter int AXI4_DATA_WIDTH = 128
) (
  input  logic                       video_clk,
  input  logic                       video_rst_n,
  input  logic                       video_vs_in,
  input  logic                       video_de_in,
  input  logic [23:0]                video_data_in,
  output logic [AXI4_DATA_WIDTH-1:0] fifo_data_out,
  output logic                       fifo_wr_en,
  input  logic                       fifo_full,
  output logic                       AXI_FULL_BURST_VALID,
  input  logic                       AXI_FULL_BURST_READY,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       fifo_overflow,
  output logic                       req_overflow
);
  localparam int LANES = lanes_of(AXI4_DATA_WIDTH);
  localparam int LW    = $clog2(V_DISP + 1);
  localparam logic [LW-1:0] VD = LW'(V_DISP);

  if ((H_DISP % LANES) != 0) begin : g_hdisp_chk
    $error("H_DISP must be a multiple of LANES");
  end

  logic              vs_q, de_q, armed_q;
  logic              frame_start_q, frame_done_q, fifo_ovf_q, req_ovf_q;
  logic [LW-1:0]     line_cnt_q;
  logic [PEND_W-1:0] pend_q;
  logic              fs, active, pix_vld, line_end, hs, drop;

  assign fs       = video_vs_in & ~vs_q;
  // frame start wins over any pixel or line end sampled on the same edge
  assign active   = armed_q & (line_cnt_q < VD) & ~fs;
  assign pix_vld  = active & video_de_in;
  assign line_end = active & ~video_de_in & de_q;
  assign hs       = (pend_q != '0) & AXI_FULL_BURST_READY;

  video_pixel_packer #(.W(AXI4_DATA_WIDTH)) u_packer (
    .clk         (video_clk),
    .rst_n       (video_rst_n),
    .clr_i       (fs),
    .pix_vld_i   (pix_vld),
    .line_end_i  (line_end),
    .fifo_full_i (fifo_full),
    .pix_i       (video_data_in),
    .fifo_data_o (fifo_data_out),
    .fifo_wr_en_o(fifo_wr_en),
    .drop_o      (drop)
  );

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      fifo_ovf_q    <= 1'b0;
      req_ovf_q     <= 1'b0;
      line_cnt_q    <= '0;
      pend_q        <= '0;
    end else begin
      vs_q          <= video_vs_in;
      de_q          <= video_de_in;
      frame_start_q <= fs;
      frame_done_q  <= line_end & ((line_cnt_q + LW'(1)) == VD);
      if (fs) armed_q <= 1'b1;

      if (fs)            line_cnt_q <= '0;
      else if (line_end) line_cnt_q <= line_cnt_q + LW'(1);

      if (line_end && !hs && pend_q != '1) pend_q <= pend_q + PEND_W'(1);
      else if (!line_end && hs)            pend_q <= pend_q - PEND_W'(1);

      if (fs)                                 req_ovf_q <= 1'b0;
      else if (line_end && !hs && pend_q == '1) req_ovf_q <= 1'b1;

      if (fs)        fifo_ovf_q <= 1'b0;
      else if (drop) fifo_ovf_q <= 1'b1;
    end
  end

  assign AXI_FULL_BURST_VALID = (pend_q != '0);
  assign frame_start          = frame_start_q;
  assign frame_done           = frame_done_q;
  assign fifo_overflow        = fifo_ovf_q;
  assign req_overflow         = req_ovf_q;
endmodule

// File: tb/tb_video_to_fifo_ctrl.sv
// Directed bench for video_to_fifo_ctrl: H_DISP=8, V_DISP=2, 128-bit words.
module tb_video_to_fifo_ctrl;
  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0, de = 1'b0, full = 1'b0, ready = 1'b0;
  logic [23:0]   data = '0;
  logic [W-1:0]  fdata;
  logic          wr_en, valid, fstart, fdone, fovf, rovf;

  int n_run = 0, n_fail = 0;
  int fs_cnt = 0, fd_cnt = 0, hs_cnt = 0;
  logic [W-1:0] wq[$];

  video_to_fifo_ctrl #(.H_DISP(8), .V_DISP(2), .AXI4_DATA_WIDTH(W)) dut (
    .video_clk(clk), .video_rst_n(rst_n), .video_vs_in(vs), .video_de_in(de),
    .video_data_in(data), .fifo_data_out(fdata), .fifo_wr_en(wr_en), .fifo_full(full),
    .AXI_FULL_BURST_VALID(valid), .AXI_FULL_BURST_READY(ready),
    .frame_start(fstart), .frame_done(fdone), .fifo_overflow(fovf), .req_overflow(rovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wq.push_back(fdata);
    if (fstart) fs_cnt++;
    if (fdone) fd_cnt++;
    if (valid && ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
  endtask

  // n pixels base..base+n-1; fifo_full raised from pixel index full_from on
  task automatic line(input int n, input int base, input int full_from);
    for (int i = 0; i < n; i++) begin
      de = 1'b1; data = 24'(base + i);
      full = (i >= full_from);
      tick();
    end
    de = 1'b0; full = 1'b0; data = '0;
    tick(); tick(); tick();
  endtask

  task automatic drain(input int cycles);
    ready = 1'b1;
    repeat (cycles) tick();
    ready = 1'b0; tick();
  endtask

  initial begin
    #1;
    chk("rst_outputs", {fdata, wr_en, valid, fstart, fdone, fovf, rovf}, '0);
    tick(); rst_n = 1'b1; tick();

    // activity before the first vs is ignored
    line(8, 1, 99);
    chk("pre_arm_writes", wq.size(), 0);
    chk("pre_arm_valid", valid, 0);

    // frame: two full lines
    vs_pulse();
    chk("frame_start_pulse", fs_cnt, 1);
    line(8, 1, 99);
    chk("l1_writes", wq.size(), 2);
    chk("l1_word0", wq[0], 128'h00000001_00000002_00000003_00000004);
    chk("l1_word1", wq[1], 128'h00000005_00000006_00000007_00000008);
    chk("l1_valid", valid, 1);
    chk("l1_no_done", fd_cnt, 0);
    line(8, 9, 99);
    chk("l2_writes", wq.size(), 4);
    chk("l2_word1", wq[3], 128'h0000000d_0000000e_0000000f_00000010);
    chk("frame_done", fd_cnt, 1);
    hs_cnt = 0;
    drain(5);
    chk("two_handshakes", hs_cnt, 2);
    chk("valid_drained", valid, 0);
    // third line beyond V_DISP is ignored
    wq.delete();
    line(8, 1, 99);
    chk("extra_line_writes", wq.size(), 0);
    chk("extra_line_valid", valid, 0);
    chk("extra_line_done", fd_cnt, 1);

    // partial line flush
    vs_pulse();
    line(6, 1, 99);
    chk("partial_writes", wq.size(), 2);
    chk("partial_flush", wq[1], 128'h00000005_00000006_00000000_00000000);
    hs_cnt = 0;
    drain(4);
    chk("partial_one_req", hs_cnt, 1);

    // request saturation: pend_cnt survives vs
    vs_pulse();
    line(8, 1, 99); line(8, 1, 99);
    vs_pulse();
    line(8, 1, 99);
    chk("sat_no_ovf_yet", rovf, 0);
    line(8, 1, 99);
    chk("req_overflow", rovf, 1);
    chk("sat_valid", valid, 1);
    hs_cnt = 0;
    ready = 1'b1;
    tick(); tick();
    chk("valid_after_2hs", valid, 1);
    tick(); tick(); tick();
    ready = 1'b0; tick();
    chk("sat_three_hs", hs_cnt, 3);
    chk("sat_valid_drop", valid, 0);

    // fifo full during second word of a line
    vs_pulse();
    chk("rovf_cleared", rovf, 0);
    wq.delete();
    line(8, 1, 4);
    chk("full_writes", wq.size(), 1);
    chk("full_word0", wq[0], 128'h00000001_00000002_00000003_00000004);
    chk("fifo_overflow", fovf, 1);
    vs_pulse();
    chk("fovf_cleared", fovf, 0);
    drain(3);

    // reset mid-line with a pending request
    line(8, 1, 99);
    chk("pre_rst_valid", valid, 1);
    wq.delete();
    de = 1'b1; data = 24'h000031; tick();
    data = 24'h000032; tick();
    rst_n = 1'b0; #1;
    chk("rst_mid_outputs", {fdata, wr_en, valid, fstart, fdone, fovf, rovf}, '0);
    tick(); rst_n = 1'b1; de = 1'b0; tick();
    line(8, 1, 99);
    chk("post_rst_writes", wq.size(), 0);
    chk("post_rst_valid", valid, 0);
    vs_pulse();
    line(8, 0, 99);
    chk("rearm_writes", wq.size(), 2);
    chk("rearm_word0", wq[0], 128'h00000000_00000001_00000002_00000003);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
